// File: rtl/main.sv
// rtl/main.sv - A5/1-style majority-clocked keystream generator
module main (
    input  logic        clk,
    input  logic        load,
    input  logic [63:0] key,
    output logic        encryption
);

    logic [18:0] r1_q, r1_d;
    logic [21:0] r2_q, r2_d;
    logic [22:0] r3_q, r3_d;
    logic        maj;

    // Majority vote over the clocking taps; each register advances only if it agrees
    always_comb begin
        r1_d = r1_q;
        r2_d = r2_q;
        r3_d = r3_q;
        maj  = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
        if (r1_q[8] == maj) begin
            r1_d = {r1_q[17:0], r1_q[18] ^ r1_q[17] ^ r1_q[16] ^ r1_q[13]};
        end
        if (r2_q[10] == maj) begin
            r2_d = {r2_q[20:0], r2_q[21] ^ r2_q[20]};
        end
        if (r3_q[10] == maj) begin
            r3_d = {r3_q[21:0], r3_q[22] ^ r3_q[21] ^ r3_q[20] ^ r3_q[7]};
        end
    end

    // Load restarts the sequence from the key with no step on that edge
    always_ff @(posedge clk) begin
        if (load) begin
            r1_q <= key[63:45];
            r2_q <= key[44:23];
            r3_q <= key[22:0];
        end else begin
            r1_q <= r1_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
        end
    end

    // Keystream bit taken straight from the register MSBs, no output stage
    assign encryption = r1_q[18] ^ r2_q[21] ^ r3_q[22];

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - self-checking bench for the majority-clocked keystream generator
module tb_main;

    logic        clk = 1'b0;
    logic        load = 1'b1;
    logic [63:0] key = '0;
    logic        encryption;

    always #5 clk = ~clk;

    main dut (
        .clk        (clk),
        .load       (load),
        .key        (key),
        .encryption (encryption)
    );

    localparam logic [31:0] TAP1 = 32'h0007_2000;
    localparam logic [31:0] TAP2 = 32'h0030_0000;
    localparam logic [31:0] TAP3 = 32'h0070_0080;

    int n_vec = 0;
    int n_bad = 0;
    logic [31:0] m1, m2, m3;

    typedef struct {
        logic [63:0] key;
        int          steps;
        logic        enc;
        logic [18:0] r1;
        logic [21:0] r2;
        logic [22:0] r3;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [31:0] adv(input logic [31:0] r, input int len, input logic [31:0] taps);
        logic fb;
        fb = ^(r & taps);
        return ((r << 1) | {31'd0, fb}) & ((32'd1 << len) - 32'd1);
    endfunction

    task automatic model_load(input logic [63:0] k);
        m1 = {13'd0, k[63:45]};
        m2 = {10'd0, k[44:23]};
        m3 = {9'd0, k[22:0]};
    endtask

    task automatic model_step();
        int   votes;
        logic mj;
        votes = int'(m1[8]) + int'(m2[10]) + int'(m3[10]);
        mj = (votes >= 2);
        if (m1[8] == mj) m1 = adv(m1, 19, TAP1);
        if (m2[10] == mj) m2 = adv(m2, 22, TAP2);
        if (m3[10] == mj) m3 = adv(m3, 23, TAP3);
    endtask

    function automatic logic model_bit();
        return m1[18] ^ m2[21] ^ m3[22];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [63:0] k);
        key  = k;
        load = 1'b1;
        tick();
        load = 1'b0;
        model_load(k);
    endtask

    task automatic run_random(input logic [63:0] k, input int n);
        logic [31:0] p1, p2, p3;
        logic        mj;
        logic        s1, s2, s3;
        int          cnt;
        do_load(k);
        check("rand_enc_step0", 64'(encryption), 64'(model_bit()));
        for (int i = 0; i < n; i++) begin
            p1 = 32'(dut.r1_q);
            p2 = 32'(dut.r2_q);
            p3 = 32'(dut.r3_q);
            tick();
            model_step();
            check("rand_enc", 64'(encryption), 64'(model_bit()));
            check("rand_regs", {dut.r1_q, dut.r2_q, dut.r3_q}, {m1[18:0], m2[21:0], m3[22:0]});
            mj = (int'(p1[8]) + int'(p2[10]) + int'(p3[10])) >= 2;
            s1 = (32'(dut.r1_q) == adv(p1, 19, TAP1));
            s2 = (32'(dut.r2_q) == adv(p2, 22, TAP2));
            s3 = (32'(dut.r3_q) == adv(p3, 23, TAP3));
            cnt = int'(s1) + int'(s2) + int'(s3);
            check("steps_ge2", 64'(cnt >= 2), 64'd1);
            if (!s1) check("hold_r1", 64'((32'(dut.r1_q) == p1) && (p1[8] != mj)), 64'd1);
            if (!s2) check("hold_r2", 64'((32'(dut.r2_q) == p2) && (p2[10] != mj)), 64'd1);
            if (!s3) check("hold_r3", 64'((32'(dut.r3_q) == p3) && (p3[10] != mj)), 64'd1);
        end
    endtask

    logic [63:0] s_a[64];
    logic [63:0] s_b[64];
    logic [63:0] data[64];
    logic [63:0] ct[64];
    logic        seq_a[100];
    logic        seq_b[100];
    logic [63:0] k_fix;

    initial begin
        // Hand-derived walks for single-bit keys: bit climbs to the clocking tap then stalls
        vecs[0]  = '{64'h8000_0000_0000_0000, 0,  1'b1, 19'h40000, 22'h0,      23'h0};
        vecs[1]  = '{64'h8000_0000_0000_0000, 1,  1'b0, 19'h00001, 22'h0,      23'h0};
        vecs[2]  = '{64'h8000_0000_0000_0000, 5,  1'b0, 19'h00010, 22'h0,      23'h0};
        vecs[3]  = '{64'h8000_0000_0000_0000, 9,  1'b0, 19'h00100, 22'h0,      23'h0};
        vecs[4]  = '{64'h8000_0000_0000_0000, 12, 1'b0, 19'h00100, 22'h0,      23'h0};
        vecs[5]  = '{64'h0000_1000_0000_0000, 0,  1'b1, 19'h0,     22'h200000, 23'h0};
        vecs[6]  = '{64'h0000_1000_0000_0000, 1,  1'b0, 19'h0,     22'h000001, 23'h0};
        vecs[7]  = '{64'h0000_1000_0000_0000, 11, 1'b0, 19'h0,     22'h000400, 23'h0};
        vecs[8]  = '{64'h0000_1000_0000_0000, 15, 1'b0, 19'h0,     22'h000400, 23'h0};
        vecs[9]  = '{64'h0000_0000_0040_0000, 0,  1'b1, 19'h0,     22'h0,      23'h400000};
        vecs[10] = '{64'h0000_0000_0040_0000, 1,  1'b0, 19'h0,     22'h0,      23'h000001};
        vecs[11] = '{64'h0000_0000_0040_0000, 9,  1'b0, 19'h0,     22'h0,      23'h000101};
        vecs[12] = '{64'h0000_0000_0040_0000, 14, 1'b0, 19'h0,     22'h0,      23'h000404};
        vecs[13] = '{64'h0000_0000_0000_0000, 0,  1'b0, 19'h0,     22'h0,      23'h0};
        vecs[14] = '{64'h0000_0000_0000_0000, 20, 1'b0, 19'h0,     22'h0,      23'h0};
        vecs[15] = '{64'hFFFF_FFFF_FFFF_FFFF, 0,  1'b1, 19'h7FFFF, 22'h3FFFFF, 23'h7FFFFF};

        for (int v = 0; v < 16; v++) begin
            do_load(vecs[v].key);
            for (int s = 0; s < vecs[v].steps; s++) tick();
            check("tbl_enc", 64'(encryption), 64'(vecs[v].enc));
            check("tbl_r1", 64'(dut.r1_q), 64'(vecs[v].r1));
            check("tbl_r2", 64'(dut.r2_q), 64'(vecs[v].r2));
            check("tbl_r3", 64'(dut.r3_q), 64'(vecs[v].r3));
        end

        // All-zero key keeps the stream at zero every cycle
        do_load(64'h0);
        for (int i = 0; i < 20; i++) begin
            check("zero_key_enc", 64'(encryption), 64'd0);
            tick();
        end

        // Load held high: key reloaded every edge, output stays at step-0 value
        k_fix = 64'h6861_7264_7761_7265;
        model_load(k_fix);
        key  = k_fix;
        load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_load_enc", 64'(encryption), 64'(model_bit()));
            check("hold_load_regs", {dut.r1_q, dut.r2_q, dut.r3_q}, k_fix);
        end
        load = 1'b0;

        // Mid-stream reload restarts the sequence
        do_load(k_fix);
        for (int i = 0; i < 100; i++) begin
            seq_a[i] = encryption;
            tick();
        end
        do_load(k_fix);
        for (int i = 0; i < 100; i++) begin
            seq_b[i] = encryption;
            tick();
        end
        for (int i = 0; i < 100; i++) check("reload_repeat", 64'(seq_b[i]), 64'(seq_a[i]));

        // Encrypt then decrypt with a regenerated stream
        do_load(k_fix);
        for (int w = 0; w < 64; w++) begin
            for (int b = 0; b < 64; b++) begin
                s_a[w][b] = encryption;
                tick();
            end
            data[w] = {$urandom, $urandom};
            ct[w] = data[w] ^ s_a[w];
        end
        do_load(k_fix);
        for (int w = 0; w < 64; w++) begin
            for (int b = 0; b < 64; b++) begin
                s_b[w][b] = encryption;
                tick();
            end
        end
        for (int w = 0; w < 64; w++) begin
            check("stream_repeat", s_b[w], s_a[w]);
            check("xor_roundtrip", ct[w] ^ s_b[w], data[w]);
        end

        // Model comparison against fixed and random keys
        run_random(k_fix, 10000);
        run_random({$urandom, $urandom}, 10000);
        run_random({$urandom, $urandom}, 10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
